fixed_to_float_pipe: RTL and testbench

//  Pipelined, parametrised signed fixed-point to IEEE-style float converter. It is the clocked successor of the combinational
//  16-bit converter, adding valid/ready flow control, selectable rounding, and overflow/underflow flags.

---
 rtl/fixed_to_float_pipe.sv | 140 ++++++++++++++
 tb/tb_fixed_to_float_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_to_float_pipe.sv
// Three-stage signed fixed-point to float converter with valid/ready flow control,
// selectable round-nearest-even / truncate, and overflow / underflow flags.
module fixed_to_float_pipe #(
    parameter int FIX_W  = 16,
    parameter int FRAC_W = 8,
    parameter int EXP_W  = 5,
    parameter int MAN_W  = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rnd_mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FIX_W-1:0]       fixed_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   float_out,
    output logic                   out_ovf,
    output logic                   out_unf
);

    localparam int PW    = (FIX_W > 1) ? $clog2(FIX_W) : 1;
    localparam int EW    = EXP_W + 2;
    localparam int BIAS  = 2**(EXP_W-1) - 1;
    localparam int EXT_W = (FIX_W - 1) + MAN_W + 2;
    localparam logic signed [EW-1:0] E_MAX  = EW'(2**EXP_W - 1);
    localparam logic signed [EW-1:0] E_ZERO = '0;

    logic [3:1] vld_pipe;
    logic       stall, adv;

    assign stall     = out_valid & ~out_ready;
    assign adv       = ~stall;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[3];

    // ---------------- stage 1: sign / magnitude ----------------
    logic [FIX_W-1:0] mag_c;
    logic             s1_sign, s1_rnd;
    logic [FIX_W-1:0] s1_mag;

    assign mag_c = fixed_in[FIX_W-1] ? (~fixed_in + FIX_W'(1)) : fixed_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sign <= 1'b0;
            s1_rnd  <= 1'b0;
            s1_mag  <= '0;
        end else if (adv && in_valid) begin
            s1_sign <= fixed_in[FIX_W-1];
            s1_rnd  <= rnd_mode;
            s1_mag  <= mag_c;
        end
    end

    // ---------------- stage 2: leading one / normalise ----------------
    logic [PW-1:0]    lead_p;
    logic [FIX_W-1:0] norm_c;
    logic             s2_sign, s2_rnd;
    logic [PW-1:0]    s2_p;
    logic [FIX_W-1:0] s2_norm;

    always_comb begin
        lead_p = '0;
        for (int i = 0; i < FIX_W; i++)
            if (s1_mag[i]) lead_p = PW'(i);
    end

    assign norm_c = s1_mag << (PW'(FIX_W - 1) - lead_p);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_sign <= 1'b0;
            s2_rnd  <= 1'b0;
            s2_p    <= '0;
            s2_norm <= '0;
        end else if (adv && vld_pipe[1]) begin
            s2_sign <= s1_sign;
            s2_rnd  <= s1_rnd;
            s2_p    <= lead_p;
            s2_norm <= norm_c;
        end
    end

    // ---------------- stage 3: round / bias / pack ----------------
    // After normalisation the MSB is set for every nonzero input, so it doubles as the zero flag.
    logic                   s2_zero;
    logic [EXT_W-1:0]       ext;
    logic [MAN_W-1:0]       man;
    logic                   guard, sticky, inc;
    logic [MAN_W:0]         man_r;
    logic signed [EW-1:0]   e_base, e_r;
    logic [EXP_W+MAN_W:0]   res_c;
    logic                   ovf_c, unf_c;

    assign s2_zero = ~s2_norm[FIX_W-1];
    assign ext     = {s2_norm[FIX_W-2:0], {(MAN_W+2){1'b0}}};
    assign man     = ext[EXT_W-1 -: MAN_W];
    assign guard   = ext[EXT_W-1-MAN_W];
    assign sticky  = |ext[EXT_W-2-MAN_W:0];
    assign inc     = ~s2_rnd & guard & (sticky | man[0]);
    assign man_r   = {1'b0, man} + (MAN_W+1)'(inc);
    assign e_base  = $signed(EW'(s2_p) + EW'(BIAS) - EW'(FRAC_W));
    // A mantissa carry leaves man_r[MAN_W-1:0] all-zero, so only the exponent moves.
    assign e_r     = e_base + $signed(EW'(man_r[MAN_W]));

    always_comb begin
        res_c = '0;
        ovf_c = 1'b0;
        unf_c = 1'b0;
        if (s2_zero) begin
            res_c = '0;
        end else if (e_r >= E_MAX) begin
            res_c = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_c = 1'b1;
        end else if (e_r <= E_ZERO) begin
            res_c = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
            unf_c = 1'b1;
        end else begin
            res_c = {s2_sign, e_r[EXP_W-1:0], man_r[MAN_W-1:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            float_out <= '0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[2:1], in_valid};
            if (vld_pipe[2]) begin
                float_out <= res_c;
                out_ovf   <= ovf_c;
                out_unf   <= unf_c;
            end
        end
    end

endmodule

// File: tb/tb_fixed_to_float_pipe.sv
// Scoreboard bench: three converter configs share one input stream; a monitor pops
// expectations from per-config queues and checks flow control, hold and latency.
module tb_fixed_to_float_pipe;

    logic        clk = 0, rst = 1, rnd_mode = 0, in_valid = 0, out_ready = 1;
    logic [15:0] fixed_in = '0;
    logic        in_ready0, in_ready1, in_ready2;
    logic        out_valid0, out_valid1, out_valid2;
    logic        ovf0, ovf1, ovf2, unf0, unf1, unf2;
    logic [15:0] f0;
    logic [7:0]  f1, f2;

    always #5 clk = ~clk;

    fixed_to_float_pipe u_h (
        .clk(clk), .rst(rst), .rnd_mode(rnd_mode), .in_valid(in_valid), .in_ready(in_ready0),
        .fixed_in(fixed_in), .out_valid(out_valid0), .out_ready(out_ready), .float_out(f0),
        .out_ovf(ovf0), .out_unf(unf0));

    fixed_to_float_pipe #(.FIX_W(16), .FRAC_W(0), .EXP_W(4), .MAN_W(3)) u_o (
        .clk(clk), .rst(rst), .rnd_mode(rnd_mode), .in_valid(in_valid), .in_ready(in_ready1),
        .fixed_in(fixed_in), .out_valid(out_valid1), .out_ready(out_ready), .float_out(f1),
        .out_ovf(ovf1), .out_unf(unf1));

    fixed_to_float_pipe #(.FIX_W(16), .FRAC_W(15), .EXP_W(4), .MAN_W(3)) u_u (
        .clk(clk), .rst(rst), .rnd_mode(rnd_mode), .in_valid(in_valid), .in_ready(in_ready2),
        .fixed_in(fixed_in), .out_valid(out_valid2), .out_ready(out_ready), .float_out(f2),
        .out_ovf(ovf2), .out_unf(unf2));

    typedef struct { logic [17:0] r; int acc; } exp_t;
    exp_t q0[$], q1[$], q2[$];

    int n_chk = 0, n_fail = 0, cyc = 0, rdy_mode = 0, stall_from = 0;
    bit lat_chk = 0;

    // Reference: value = x / 2^fw; significand by integer division, remainder drives rounding.
    function automatic logic [17:0] model(int fw, int ew, int mw, logic [15:0] x, bit trunc);
        longint v, mag, scaled, den, q, r;
        int msb, e, bias, f;
        bit s;
        v   = longint'($signed(x));
        s   = (v < 0);
        mag = s ? -v : v;
        if (mag == 0) return 18'h0;
        msb = 0;
        while ((longint'(1) << (msb + 1)) <= mag) msb++;
        scaled = mag << mw;
        den    = longint'(1) << msb;
        q      = scaled / den;
        r      = scaled % den;
        if (!trunc && ((2*r > den) || (2*r == den && (q % 2) == 1))) q++;
        bias = (1 << (ew - 1)) - 1;
        e    = msb - fw + bias;
        if (q == (longint'(1) << (mw + 1))) begin
            q = longint'(1) << mw;
            e++;
        end
        if (e >= (1 << ew) - 1) begin
            f = (int'(s) << (ew + mw)) | (((1 << ew) - 1) << mw);
            return {2'b10, 16'(f)};
        end else if (e <= 0) begin
            f = int'(s) << (ew + mw);
            return {2'b01, 16'(f)};
        end
        f = (int'(s) << (ew + mw)) | (e << mw) | int'(q - (longint'(1) << mw));
        return {2'b00, 16'(f)};
    endfunction

    task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic fail(string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = !(cyc >= stall_from && cyc < stall_from + 5);
        endcase
    endtask

    task automatic send(logic [15:0] x, bit r, int e0 = -1, int e1 = -1, int e2 = -1);
        bit done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            step();
            in_valid = 1'b1;
            fixed_in = x;
            rnd_mode = r;
            #1;
            if (in_ready0) begin
                done = 1;
                q0.push_back('{(e0 < 0) ? model(8, 5, 10, x, r)  : 18'(e0), cyc});
                q1.push_back('{(e1 < 0) ? model(0, 4, 3, x, r)   : 18'(e1), cyc});
                q2.push_back('{(e2 < 0) ? model(15, 4, 3, x, r)  : 18'(e2), cyc});
            end
        end
        if (!done) fail("send timeout");
    endtask

    task automatic drain();
        int k = 0;
        while ((q0.size() != 0 || q1.size() != 0 || q2.size() != 0) && k < 500) begin
            step();
            in_valid = 1'b0;
            k++;
        end
        if (k >= 500) fail("drain timeout");
    endtask

    // Monitor
    bit          held = 0;
    logic [15:0] pf = '0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                held = 0;
            end else begin
                check("in_ready", 32'(in_ready0), 32'(!(out_valid0 && !out_ready)));
                if (held) check("hold_float", 32'(f0), 32'(pf));
                held = out_valid0 && !out_ready;
                pf   = f0;
                if (out_valid0 && out_ready) begin
                    if (q0.size() == 0) fail("unexpected word h");
                    else begin
                        e = q0.pop_front();
                        check("word_h", 32'({ovf0, unf0, f0}), 32'(e.r));
                        if (lat_chk) check("latency", 32'(cyc - e.acc), 32'd3);
                    end
                end
                if (out_valid1 && out_ready) begin
                    if (q1.size() == 0) fail("unexpected word o");
                    else begin
                        e = q1.pop_front();
                        check("word_o", 32'({ovf1, unf1, 8'h00, f1}), 32'(e.r));
                    end
                end
                if (out_valid2 && out_ready) begin
                    if (q2.size() == 0) fail("unexpected word u");
                    else begin
                        e = q2.pop_front();
                        check("word_u", 32'({ovf2, unf2, 8'h00, f2}), 32'(e.r));
                    end
                end
            end
        end
    end

    initial begin
        logic [15:0] x;
        logic [15:0] sp [4];
        sp[0] = 16'h7FFF; sp[1] = 16'h8000; sp[2] = 16'h0000; sp[3] = 16'hFFFF;

        // reset state
        #1;
        check("rst_valid", 32'(out_valid0), 32'd0);
        check("rst_float", 32'(f0), 32'd0);
        check("rst_flags", 32'({ovf0, unf0}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 0;
        #1 check("rdy_after_rst", 32'(in_ready0), 32'd1);

        // directed stream and rounding cases
        rdy_mode = 0;
        lat_chk  = 1;
        send(16'h4000, 0, 'h5400);
        send(16'hC000, 0, 'h0D400);
        send(16'h0001, 0, 'h1C00);
        send(16'h0000, 0, 'h0000);
        send(16'hFFFF, 0, 'h9C00);
        send(16'h8000, 0, 'hD800);
        send(16'h7FFF, 0, 'h5800);
        send(16'h7FFF, 1, 'h57FF);
        send(16'h0801, 0, 'h4800);
        send(16'h0803, 0, 'h4802);
        // overflow / underflow configs
        send(16'h7FFF, 0, 'h5800, 'h20078);
        send(16'h0001, 0, 'h1C00, -1, 'h10000);
        drain();

        // backpressure window in the middle of an 8-word stream
        lat_chk    = 0;
        rdy_mode   = 2;
        stall_from = cyc + 5;
        for (int i = 0; i < 8; i++) send(16'($urandom), 1'($urandom));
        drain();

        // async reset with words in flight
        rdy_mode = 0;
        send(16'h4000, 0);
        send(16'hC000, 0);
        send(16'h7FFF, 0);
        @(posedge clk);
        #2;
        rst      = 1;
        in_valid = 0;
        #1;
        check("midrst_valid", 32'(out_valid0), 32'd0);
        check("midrst_float", 32'(f0), 32'd0);
        q0.delete(); q1.delete(); q2.delete();
        @(negedge clk);
        rst     = 0;
        lat_chk = 1;
        send(16'h0100, 0, 'h3C00);
        drain();

        // randomized traffic with random backpressure
        lat_chk  = 0;
        rdy_mode = 1;
        for (int i = 0; i < 10000; i++) begin
            case ($urandom_range(0, 3))
                0:       x = sp[$urandom_range(0, 3)];
                1:       x = 16'($urandom_range(0, 15)) ^ {16{1'($urandom)}};
                default: x = 16'($urandom);
            endcase
            send(x, 1'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                step();
                in_valid = 1'b0;
            end
        end
        drain();
        check("leftover", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
